// File: rtl/main_memory_responder_if.sv
// Cache <-> main memory handshake bundle. The cache controller (master) holds
// mem_read/mem_write until it sees the one-cycle mem_ready pulse from memory.
interface main_memory_responder_if #(
  parameter int TAG_WIDTH    = 18,
  parameter int INDEX_WIDTH  = 10,
  parameter int OFFSET_WIDTH = 4
);
  localparam int ADDR_W = TAG_WIDTH + INDEX_WIDTH;
  localparam int LINE_W = 8 << OFFSET_WIDTH;
  localparam int BE_W   = LINE_W / 8;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;
  logic              protocol_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wbe,
    input  mem_ready, mem_rdata, busy, protocol_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wbe,
    output mem_ready, mem_rdata, busy, protocol_err
  );
endinterface

// File: rtl/main_memory_responder.sv
// Main-memory model below the cache: line-wide backing store that answers one
// outstanding read or write with a single-cycle mem_ready after a fixed latency.
// Reads return a full line; writes merge bytes selected by mem_wbe.
module main_memory_responder #(
  parameter int TAG_WIDTH      = 18,
  parameter int INDEX_WIDTH    = 10,
  parameter int OFFSET_WIDTH   = 4,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int READ_LATENCY   = 8,
  parameter int WRITE_LATENCY  = 4
) (
  input logic                     clk,
  input logic                     rst,
  main_memory_responder_if.slave  bus
);
  localparam int ADDR_W  = TAG_WIDTH + INDEX_WIDTH;
  localparam int LINE_W  = 8 << OFFSET_WIDTH;
  localparam int BE_W    = LINE_W / 8;
  localparam int DEPTH   = 1 << MEM_DEPTH_LOG2;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic                      op_write;
  logic [MEM_DEPTH_LOG2-1:0] addr_q;
  logic [LINE_W-1:0]         wdata_q;
  logic [BE_W-1:0]           wbe_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      perr_q;
  logic [LINE_W-1:0]         rdata_q;
  logic [LINE_W-1:0]         mem_array [DEPTH];

  logic                      req_any;
  logic                      acc_lat1;
  logic [MEM_DEPTH_LOG2-1:0] in_addr;

  // Only the low address bits select a line; higher bits alias onto the same store.
  assign in_addr  = bus.mem_addr[MEM_DEPTH_LOG2-1:0];
  assign req_any  = bus.mem_read | bus.mem_write;
  assign acc_lat1 = bus.mem_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);

  generate
    if (MEM_DEPTH_LOG2 < ADDR_W) begin : g_alias
      logic unused_upper_addr;
      assign unused_upper_addr = ^bus.mem_addr[ADDR_W-1:MEM_DEPTH_LOG2];
    end
  endgenerate

  assign bus.mem_ready    = ready_q;
  assign bus.mem_rdata    = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.protocol_err = perr_q;

  // Capture the request payload at acceptance; the transaction then runs on these copies.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) begin
      addr_q  <= in_addr;
      wdata_q <= bus.mem_wdata;
      wbe_q   <= bus.mem_wbe;
    end
  end

  // Transaction FSM: accept in IDLE, count down latency in WAIT, pulse ready in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      perr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            op_write <= bus.mem_write;
            busy_q   <= 1'b1;
            perr_q   <= bus.mem_write & bus.mem_read;
            cnt      <= bus.mem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            if (acc_lat1) begin
              state   <= RESP;
              ready_q <= 1'b1;
              if (!bus.mem_write) rdata_q <= mem_array[in_addr];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // The cache must hold its request until it sees ready.
          if ((op_write && !bus.mem_write) || (!op_write && !bus.mem_read)) perr_q <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= RESP;
            ready_q <= 1'b1;
            if (!op_write) rdata_q <= mem_array[addr_q];
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Byte-merge write commits on the edge that ends RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe_q[b]) mem_array[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances (latency 8/4 and latency 1/1),
// directed requests push expected responses into per-instance queues and a
// negedge monitor pops and compares on every mem_ready pulse.
module tb_main_memory_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_read;
    logic [127:0] rdata;
    int           due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic         rd   [2];
  logic         wr   [2];
  logic [27:0]  addr [2];
  logic [127:0] wd   [2];
  logic [15:0]  be   [2];
  logic [1:0]   rdy, bsy, perr;
  logic [127:0] rdat [2];

  main_memory_responder_if bus0 ();
  main_memory_responder_if bus1 ();

  assign bus0.mem_read  = rd[0];
  assign bus0.mem_write = wr[0];
  assign bus0.mem_addr  = addr[0];
  assign bus0.mem_wdata = wd[0];
  assign bus0.mem_wbe   = be[0];
  assign bus1.mem_read  = rd[1];
  assign bus1.mem_write = wr[1];
  assign bus1.mem_addr  = addr[1];
  assign bus1.mem_wdata = wd[1];
  assign bus1.mem_wbe   = be[1];
  assign rdy[0]  = bus0.mem_ready;
  assign bsy[0]  = bus0.busy;
  assign perr[0] = bus0.protocol_err;
  assign rdat[0] = bus0.mem_rdata;
  assign rdy[1]  = bus1.mem_ready;
  assign bsy[1]  = bus1.busy;
  assign perr[1] = bus1.protocol_err;
  assign rdat[1] = bus1.mem_rdata;

  main_memory_responder dut0 (.clk(clk), .rst(rst), .bus(bus0));

  main_memory_responder #(
    .READ_LATENCY (1),
    .WRITE_LATENCY(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string nm, input bit ok, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int lat_of(input int d, input bit w);
    if (d == 0) return w ? 4 : 8;
    return 1;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rdy[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready dut=%0d got=1 want=0 (cycle %0d)", d, cyc);
          end else begin
            chk($sformatf("ready_cycle dut%0d", d), cyc == e.due, 128'(cyc), 128'(e.due));
            if (e.is_read) chk($sformatf("rdata dut%0d", d), rdat[d] == e.rdata, rdat[d], e.rdata);
          end
        end
      end
    end
  end

  // Issue one request (called #1 after a posedge), hold it until ready, then drop it.
  // drop_n > 0 releases the request early, in the n-th cycle after acceptance.
  task automatic do_req(input int d, input bit r, input bit w, input logic [27:0] a,
                        input logic [127:0] wdat, input logic [15:0] wbe,
                        input logic [127:0] exp_rd, input bit exp_perr, input int drop_n);
    exp_t e;
    int   k;
    bit   got;
    k = cyc;
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdat; be[d] = wbe;
    e.is_read = !w;
    e.rdata   = exp_rd;
    e.due     = k + lat_of(d, w);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) chk($sformatf("perr_accept dut%0d", d), perr[d] == exp_perr, 128'(perr[d]), 128'(exp_perr));
      if (drop_n > 0 && n == drop_n + 1) chk($sformatf("perr_drop dut%0d", d), perr[d] == 1'b1, 128'(perr[d]), 128'(1));
      chk($sformatf("busy_inflight dut%0d", d), bsy[d] == 1'b1, 128'(bsy[d]), 128'(1));
      if (rdy[d]) got = 1'b1;
      if (drop_n > 0 && n == drop_n) begin rd[d] = 1'b0; wr[d] = 1'b0; end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout dut=%0d got=0 want=1 (cycle %0d)", d, cyc);
      if (d == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk);
    #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  localparam logic [127:0] PAT_123 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] PAT_A5  = {16{8'hA5}};
  localparam logic [127:0] PAT_5A  = {16{8'h5A}};
  localparam logic [127:0] PAT_11  = {16{8'h11}};
  localparam logic [127:0] PAT_22  = {16{8'h22}};
  localparam logic [127:0] PAT_C3  = {16{8'hC3}};
  localparam logic [127:0] PAT_3C  = {16{8'h3C}};
  localparam logic [127:0] PAT_BEEF = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF;
  localparam logic [15:0]  ALL_BE  = 16'hFFFF;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0; be[d] = '0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", rdy[d] == 1'b0, 128'(rdy[d]), 128'(0));
      chk("reset_busy",  bsy[d] == 1'b0, 128'(bsy[d]), 128'(0));
      chk("reset_perr",  perr[d] == 1'b0, 128'(perr[d]), 128'(0));
      chk("reset_rdata", rdat[d] == 128'(0), rdat[d], 128'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Read latency 8 (after prefilling the line), then back to idle.
    do_req(0, 1'b0, 1'b1, 28'h0000123, PAT_123, ALL_BE, '0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 28'h0000123, '0, '0, PAT_123, 1'b0, 0);
    @(negedge clk);
    chk("idle_ready", rdy[0] == 1'b0, 128'(rdy[0]), 128'(0));
    chk("idle_busy",  bsy[0] == 1'b0, 128'(bsy[0]), 128'(0));
    @(posedge clk);
    #1;

    // Write then read back; rdata holds afterwards.
    do_req(0, 1'b0, 1'b1, 28'h0000005, PAT_A5, ALL_BE, '0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 28'h0000005, '0, '0, PAT_A5, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdat[0] == PAT_A5, rdat[0], PAT_A5);
    @(posedge clk);
    #1;

    // wbe=0 write: handshake only, array and rdata unchanged.
    do_req(0, 1'b0, 1'b1, 28'h0000005, '0, 16'h0000, '0, 1'b0, 0);
    @(negedge clk);
    chk("rdata_hold_after_write", rdat[0] == PAT_A5, rdat[0], PAT_A5);
    @(posedge clk);
    #1;
    do_req(0, 1'b1, 1'b0, 28'h0000005, '0, '0, PAT_A5, 1'b0, 0);

    // Byte merge: low four bytes only.
    do_req(0, 1'b0, 1'b1, 28'h0000007, '0, ALL_BE, '0, 1'b0, 0);
    do_req(0, 1'b0, 1'b1, 28'h0000007, PAT_BEEF, 16'h000F, '0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 28'h0000007, '0, '0, 128'h00000000_00000000_00000000_DEADBEEF, 1'b0, 0);

    // Simultaneous read+write: error pulse, write wins with write latency.
    do_req(0, 1'b1, 1'b1, 28'h000000A, PAT_5A, ALL_BE, '0, 1'b1, 0);
    do_req(0, 1'b1, 1'b0, 28'h000000A, '0, '0, PAT_5A, 1'b0, 0);

    // Request dropped mid-WAIT: error pulse, read still completes on latched address.
    do_req(0, 1'b1, 1'b0, 28'h000000A, '0, '0, PAT_5A, 1'b0, 2);

    // Reset in the second WAIT cycle of a write aborts it.
    do_req(0, 1'b0, 1'b1, 28'h0000009, PAT_11, ALL_BE, '0, 1'b0, 0);
    k = cyc;
    wr[0] = 1'b1; addr[0] = 28'h0000009; wd[0] = PAT_22; be[0] = ALL_BE;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_cycle", cyc == k + 2, 128'(cyc), 128'(k + 2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy",  bsy[0] == 1'b0, 128'(bsy[0]), 128'(0));
    chk("abort_ready", rdy[0] == 1'b0, 128'(rdy[0]), 128'(0));
    repeat (4) @(posedge clk);
    #1;
    do_req(0, 1'b1, 1'b0, 28'h0000009, '0, '0, PAT_11, 1'b0, 0);

    // Latency-1 instance: aliasing addresses, back-to-back requests.
    do_req(1, 1'b0, 1'b1, 28'h0000000, PAT_C3, ALL_BE, '0, 1'b0, 0);
    do_req(1, 1'b1, 1'b0, 28'h0001000, '0, '0, PAT_C3, 1'b0, 0);
    do_req(1, 1'b0, 1'b1, 28'h0003000, PAT_3C, 16'h00FF, '0, 1'b0, 0);
    do_req(1, 1'b1, 1'b0, 28'h0002000, '0, '0, 128'hC3C3C3C3C3C3C3C3_3C3C3C3C3C3C3C3C, 1'b0, 0);
    do_req(1, 1'b1, 1'b1, 28'h0000000, PAT_5A, 16'hFFFF, '0, 1'b1, 0);
    do_req(1, 1'b1, 1'b0, 28'h0001000, '0, '0, PAT_5A, 1'b0, 0);

    repeat (5) @(posedge clk);
    chk("queue0_empty", q0.size() == 0, 128'(q0.size()), 128'(0));
    chk("queue1_empty", q1.size() == 0, 128'(q1.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
